mem_access: RTL and testbench

- Load/store unit that consumes the effective address and store data produced by the execute stage for LB, LBU, LH, LHU, LW, SB, SH and SW.
- Performs one transaction per instruction on the 32-bit Avalon-style data bus.
- Returns the aligned, sign- or zero-extended load result to the register writeback path.
- Sits between the ALU effective-address output and the external data memory port.

---
 rtl/mem_access_pkg.sv | 25 ++
 rtl/mem_access_if.sv | 12 +
 rtl/mem_access_load_align.sv | 22 ++
 rtl/mem_access.sv | 71 +++++++
 tb/tb_mem_access.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: opcodes, FSM states, byte-enable constants and opcode helpers for mem_access
package mem_access_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
  } opcode_t;
  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} mem_state_t;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic is_load(opcode_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction
  function automatic logic is_store(opcode_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic is_byte(opcode_t op);
    return op inside {OP_LB, OP_LBU, OP_SB};
  endfunction
  function automatic logic is_half(opcode_t op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction
  function automatic logic [3:0] byte_enable(opcode_t op, logic [1:0] a);
    return is_byte(op) ? BE_BYTE << a : is_half(op) ? BE_HALF << {a[1], 1'b0} : BE_WORD;
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: 32-bit Avalon-style data bus between the load/store unit and data memory
interface mem_access_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master(output address, read, write, byteenable, writedata, input waitrequest, readdata);
  modport slave(input address, read, write, byteenable, writedata, output waitrequest, readdata);
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: selects the addressed byte/half lane of readdata and sign- or zero-extends it
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  ea,
  input  opcode_t     opcode,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select followed by extension chosen by the load opcode
  always_comb begin
    b = readdata[{ea, 3'b000} +: 8];
    h = ea[1] ? readdata[31:16] : readdata[15:0];
    result = opcode == OP_LB  ? {{24{b[7]}}, b} :
             opcode == OP_LBU ? {24'h0, b} :
             opcode == OP_LH  ? {{16{h[15]}}, h} :
             opcode == OP_LHU ? {16'h0, h} :
             opcode == OP_LW  ? readdata : '0;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: load/store unit issuing one Avalon transaction per LB/LBU/LH/LHU/LW/SB/SH/SW; MEM_ACCESS_ALIGN_CHECK_EN enables misalignment errors
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  opcode_t     opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] rt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        addr_error_o,
  mem_access_if.master bus
);
  mem_state_t  state, state_n;
  opcode_t     op_q;
  logic [31:0] ea_q, rt_q, ld_q, ld_ext;
  logic        err_q, go, mis;
  assign go = start_i && (is_load(opcode_i) || is_store(opcode_i));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign mis = (is_half(opcode_i) && effective_address_i[0]) ||
               (opcode_i inside {OP_LW, OP_SW} && |effective_address_i[1:0]);
`else
  assign mis = 1'b0;
`endif
  load_align u_align (.readdata(bus.readdata), .ea(ea_q[1:0]), .opcode(op_q), .result(ld_ext));
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: misaligned requests skip the bus and finish immediately
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? (mis ? DONE : REQ) : IDLE;
      REQ:     state_n = bus.waitrequest ? REQ : is_load(op_q) ? RDATA : DONE;
      RDATA:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // request capture in IDLE, aligned load result capture in RDATA
  always_ff @(posedge clk)
    if (reset) begin
      op_q  <= OP_NOP;
      ea_q  <= '0;
      rt_q  <= '0;
      ld_q  <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && go) begin
      op_q  <= opcode_i;
      ea_q  <= effective_address_i;
      rt_q  <= rt_i;
      ld_q  <= '0;
      err_q <= mis;
    end else if (state == RDATA) ld_q <= ld_ext;
  // outputs decoded from state; bus signals are held constant for the whole REQ phase
  always_comb begin
    busy_o         = state != IDLE;
    done_o         = state == DONE;
    load_data_o    = state == DONE ? ld_q : '0;
    addr_error_o   = state == DONE && err_q;
    bus.read       = state == REQ && is_load(op_q);
    bus.write      = state == REQ && is_store(op_q);
    bus.address    = state == REQ ? {ea_q[31:2], 2'b00} : '0;
    bus.byteenable = state == REQ ? byte_enable(op_q, ea_q[1:0]) : '0;
    bus.writedata  = !bus.write ? '0 : is_byte(op_q) ? {4{rt_q[7:0]}} :
                     is_half(op_q) ? {2{rt_q[15:0]}} : rt_q;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven self-checking bench for mem_access with a stalling bus slave
module tb_mem_access;
  import mem_access_pkg::*;
  logic        clk = 0, reset = 1, start = 0;
  opcode_t     opcode = OP_NOP;
  logic [31:0] ea = 0, rt = 0, rdata = 0;
  logic        busy_o, done_o, addr_error_o;
  logic [31:0] load_data_o;
  int          stalls = 0, req_cycles = 0, errors = 0, checks = 0;
  mem_access_if bus();
  mem_access dut (
    .clk(clk), .reset(reset), .start_i(start), .opcode_i(opcode),
    .effective_address_i(ea), .rt_i(rt), .busy_o(busy_o), .done_o(done_o),
    .load_data_o(load_data_o), .addr_error_o(addr_error_o), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.readdata = rdata;
  assign bus.waitrequest = (bus.read || bus.write) && (req_cycles < stalls);
  always @(posedge clk) req_cycles <= (bus.read || bus.write) ? req_cycles + 1 : 0;
  typedef struct {
    opcode_t     op;
    logic [31:0] ea, rt, rd;
    int          stalls, lat;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    logic        err;
    int          rds, wrs;
  } vec_t;
  vec_t vecs[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    int k = 0, rds = 0, wrs = 0;
    logic [31:0] a = 0, wd = 0, mask;
    logic [3:0] be = 0;
    logic unstable = 0, stray = 0;
    string p = $sformatf("v%0d", idx);
    stalls = v.stalls;
    rdata = v.rd;
    @(negedge clk);
    start = 1; opcode = v.op; ea = v.ea; rt = v.rt;
    @(posedge clk);
    #1 start = 0; opcode = OP_NOP;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.read || bus.write) begin
        if (rds + wrs == 0) begin
          a = bus.address; be = bus.byteenable; wd = bus.writedata;
        end else if (a !== bus.address || be !== bus.byteenable || wd !== bus.writedata) unstable = 1;
        rds += int'(bus.read);
        wrs += int'(bus.write);
      end
      if (done_o) break;
      if (load_data_o !== 0 || addr_error_o !== 0) stray = 1;
    end
    check({p, " done"}, 32'(done_o), 1);
    check({p, " latency"}, 32'(k), 32'(v.lat));
    check({p, " busy_at_done"}, 32'(busy_o), 1);
    check({p, " load_data"}, load_data_o, v.ld);
    check({p, " addr_error"}, 32'(addr_error_o), 32'(v.err));
    check({p, " read_cycles"}, 32'(rds), 32'(v.rds));
    check({p, " write_cycles"}, 32'(wrs), 32'(v.wrs));
    check({p, " outputs_before_done"}, 32'(stray), 0);
    if (v.rds + v.wrs > 0) begin
      mask = {{8{v.be[3]}}, {8{v.be[2]}}, {8{v.be[1]}}, {8{v.be[0]}}};
      check({p, " address"}, a, {v.ea[31:2], 2'b00});
      check({p, " byteenable"}, 32'(be), 32'(v.be));
      check({p, " bus_stable"}, 32'(unstable), 0);
      if (v.wrs > 0) check({p, " writedata"}, wd & mask, v.wd & mask);
    end
    @(negedge clk);
    check({p, " back_idle"}, {30'h0, busy_o, done_o}, 0);
  endtask
  initial begin
    vecs[0]  = '{OP_SW,  32'h1000, 32'hDEADBEEF, 32'h0,        0, 2, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0, 1};
    vecs[1]  = '{OP_LB,  32'h2003, 32'h0,        32'h80112233, 0, 3, 4'h8, 32'h0,        32'hFFFFFF80, 0, 1, 0};
    vecs[2]  = '{OP_LBU, 32'h2003, 32'h0,        32'h80112233, 0, 3, 4'h8, 32'h0,        32'h00000080, 0, 1, 0};
    vecs[3]  = '{OP_SH,  32'h3002, 32'h00004142, 32'h0,        3, 5, 4'hC, 32'h41424142, 32'h0,        0, 0, 4};
    vecs[4]  = '{OP_LHU, 32'h4000, 32'h0,        32'h1234F00D, 0, 3, 4'h3, 32'h0,        32'h0000F00D, 0, 1, 0};
    vecs[5]  = '{OP_LH,  32'h4000, 32'h0,        32'h1234F00D, 0, 3, 4'h3, 32'h0,        32'hFFFFF00D, 0, 1, 0};
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    vecs[6]  = '{OP_LW,  32'h5002, 32'h0,        32'hCAFEF00D, 0, 1, 4'h0, 32'h0,        32'h0,        1, 0, 0};
`else
    vecs[6]  = '{OP_LW,  32'h5002, 32'h0,        32'hCAFEF00D, 0, 3, 4'hF, 32'h0,        32'hCAFEF00D, 0, 1, 0};
`endif
    vecs[7]  = '{OP_SB,  32'h6001, 32'h000000A5, 32'h0,        0, 2, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 0, 1};
    vecs[8]  = '{OP_LB,  32'h7001, 32'h0,        32'h12347F56, 1, 4, 4'h2, 32'h0,        32'h0000007F, 0, 2, 0};
    vecs[9]  = '{OP_LH,  32'h8002, 32'h0,        32'h9ABC0000, 0, 3, 4'hC, 32'h0,        32'hFFFF9ABC, 0, 1, 0};
    vecs[10] = '{OP_LBU, 32'h9002, 32'h0,        32'h00C30000, 0, 3, 4'h4, 32'h0,        32'h000000C3, 0, 1, 0};
    vecs[11] = '{OP_SB,  32'hA003, 32'h00000077, 32'h0,        2, 4, 4'h8, 32'h77777777, 32'h0,        0, 0, 3};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset status", {29'h0, busy_o, done_o, addr_error_o}, 0);
    check("reset load_data", load_data_o, 0);
    check("reset bus_ctl", {26'h0, bus.byteenable, bus.read, bus.write}, 0);
    check("reset address", bus.address, 0);
    for (int i = 0; i < 12; i++) run(vecs[i], i);
    @(negedge clk);
    start = 1; opcode = OP_ADD; ea = 32'h100;
    @(posedge clk);
    #1 start = 0; opcode = OP_NOP;
    @(negedge clk);
    check("nonmem ignored", {30'h0, busy_o, bus.read}, 0);
    stalls = 0;
    @(negedge clk);
    start = 1; opcode = OP_SW; ea = 32'hB000; rt = 32'h1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    @(negedge clk);
    check("done before restart", 32'(done_o), 1);
    start = 1; opcode = OP_LW; ea = 32'hC000;
    @(posedge clk);
    #1 start = 0; opcode = OP_NOP;
    @(negedge clk);
    check("start in DONE ignored", {30'h0, busy_o, bus.read}, 0);
    stalls = 100;
    @(negedge clk);
    start = 1; opcode = OP_LW; ea = 32'hD000;
    @(posedge clk);
    #1 start = 0; opcode = OP_NOP;
    @(negedge clk);
    @(negedge clk);
    check("stalled read_o", 32'(bus.read), 1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    stalls = 0;
    @(negedge clk);
    check("reset mid-REQ read_o", 32'(bus.read), 0);
    check("reset mid-REQ busy_o", 32'(busy_o), 0);
    begin
      logic seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (done_o) seen = 1;
      end
      check("no done after abort", 32'(seen), 0);
    end
    run(vecs[0], 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
